// File: rtl/uart_pkg.sv
// Shared UART framing definitions: FSM state encoding, line levels and the parity helper.
package uart_pkg;

    localparam int   DATA_BITS = 8;
    localparam logic START_LVL = 1'b0;
    localparam logic STOP_LVL  = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    function automatic logic frame_parity(input logic [DATA_BITS-1:0] byte_val, input logic odd);
        return (^byte_val) ^ odd;
    endfunction

endpackage

// File: rtl/stream_uart_tx.sv
// Stream-to-UART serializer. The start bit drives out one cycle after a transfer, and each bit lasts CLKS_PER_BAUD cycles.
// A one-entry hold register absorbs the next byte; o_ready = !hold_full, so the stream stalls while a byte waits.
module stream_uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BAUD = 868,
    parameter int OPT_PARITY    = 0,
    parameter int OPT_ODD       = 0,
    parameter int OPT_TWO_STOP  = 0
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic       i_valid,
    output logic       o_ready,
    input  logic [7:0] i_data,
    output logic       o_txd,
    output logic       o_busy
);

    if (CLKS_PER_BAUD < 2 || CLKS_PER_BAUD > 65535) begin : g_bad_baud
        $error("stream_uart_tx: CLKS_PER_BAUD must be within 2..65535");
    end

    localparam int             CW     = $clog2(CLKS_PER_BAUD);
    localparam logic [CW-1:0]  RELOAD = CW'(CLKS_PER_BAUD - 1);

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [2:0]    bit_idx, bit_idx_nxt;
    logic [7:0]    shift, shift_nxt;
    logic [7:0]    hold, hold_nxt;
    logic          hold_full, hold_full_nxt;
    logic          par, par_nxt;
    logic          txd, txd_nxt;

    logic          xfer;
    logic          last_stop;
    logic          load_req;
    logic [7:0]    load_val;

    assign xfer      = i_valid && !hold_full;
    assign last_stop = (OPT_TWO_STOP == 0) || (bit_idx == 3'd1);

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        bit_idx_nxt   = bit_idx;
        shift_nxt     = shift;
        hold_nxt      = hold;
        hold_full_nxt = hold_full;
        par_nxt       = par;
        txd_nxt       = txd;
        load_req      = 1'b0;
        load_val      = 8'h00;

        if (state == IDLE) begin
            txd_nxt = STOP_LVL;
            if (xfer) begin
                load_req = 1'b1;
                load_val = i_data;
            end
        end else begin
            if (xfer) begin
                hold_nxt      = i_data;
                hold_full_nxt = 1'b1;
            end
            if (cnt != '0) begin
                cnt_nxt = cnt - 1'b1;
            end else begin
                cnt_nxt = RELOAD;
                case (state)
                    START: begin
                        state_nxt   = DATA;
                        bit_idx_nxt = 3'd0;
                        txd_nxt     = shift[0];
                    end
                    DATA: begin
                        bit_idx_nxt = bit_idx + 3'd1;
                        if (bit_idx == 3'(DATA_BITS - 1)) begin
                            if (OPT_PARITY != 0) begin
                                state_nxt = PARITY;
                                txd_nxt   = par;
                            end else begin
                                state_nxt = STOP;
                                txd_nxt   = STOP_LVL;
                            end
                        end else begin
                            shift_nxt = {1'b0, shift[7:1]};
                            txd_nxt   = shift[1];
                        end
                    end
                    PARITY: begin
                        state_nxt = STOP;
                        txd_nxt   = STOP_LVL;
                    end
                    STOP: begin
                        if (!last_stop) begin
                            bit_idx_nxt = 3'd1;
                            txd_nxt     = STOP_LVL;
                        end else begin
                            bit_idx_nxt = 3'd0;
                            // Held byte wins; a fresh byte can only arrive here when hold is empty.
                            if (hold_full) begin
                                load_req      = 1'b1;
                                load_val      = hold;
                                hold_full_nxt = 1'b0;
                            end else if (xfer) begin
                                load_req      = 1'b1;
                                load_val      = i_data;
                                hold_full_nxt = 1'b0;
                            end else begin
                                state_nxt = IDLE;
                                txd_nxt   = STOP_LVL;
                                cnt_nxt   = '0;
                            end
                        end
                    end
                    default: begin
                        state_nxt = IDLE;
                        txd_nxt   = STOP_LVL;
                        cnt_nxt   = '0;
                    end
                endcase
            end
        end

        if (load_req) begin
            shift_nxt = load_val;
            par_nxt   = frame_parity(load_val, OPT_ODD != 0);
            state_nxt = START;
            txd_nxt   = START_LVL;
            cnt_nxt   = RELOAD;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= 3'd0;
            shift     <= 8'h00;
            hold      <= 8'h00;
            hold_full <= 1'b0;
            par       <= 1'b0;
            txd       <= STOP_LVL;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            bit_idx   <= bit_idx_nxt;
            shift     <= shift_nxt;
            hold      <= hold_nxt;
            hold_full <= hold_full_nxt;
            par       <= par_nxt;
            txd       <= txd_nxt;
        end
    end

    assign o_txd   = txd;
    assign o_ready = !hold_full;
    assign o_busy  = (state != IDLE) || hold_full;

endmodule
